sum_accumulator: RTL and testbench



---
 rtl/sum_accumulator_if.sv | 28 ++
 rtl/sum_accumulator.sv | 141 ++++++++++++++
 tb/tb_sum_accumulator.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sum_accumulator_if.sv
// Bus between the accumulate-on-keypress stage and its surroundings.
// The master side (board top level or bench) drives the adder result,
// the load key and clear. The slave side (sum_accumulator) returns the
// running total, its status and the 7-segment codes.
interface sum_accumulator_if #(
  parameter int ACC_W = 8
);
  logic [4:0]       sum_in;
  logic             load_key;
  logic             clear;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [3:0]       count;
  logic             acc_valid;
  logic             busy;
  logic [6:0]       HEX0;
  logic [6:0]       HEX1;

  modport master (
    output sum_in, load_key, clear,
    input  acc, ovf, count, acc_valid, busy, HEX0, HEX1
  );

  modport slave (
    input  sum_in, load_key, clear,
    output acc, ovf, count, acc_valid, busy, HEX0, HEX1
  );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulate-on-keypress stage behind the 4-bit ripple-carry adder.
// A debounced load key adds the 5-bit adder result into an ACC_W-bit
// running total, shown on LEDs and two hex digits, with sticky overflow.
//
// state        | meaning
// -------------+--------------------------------------------------------
// IDLE         | waiting for the synchronized key to go high
// DEBOUNCE     | key high; timer counting down to acceptance
// ACCUM        | single cycle; total updated on the exiting edge
// WAIT_RELEASE | one accumulation per press; wait for key release
module sum_accumulator #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACC_W           = 8
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  sum_accumulator_if.slave bus
);

  // Three spare bits of headroom over what the hold time needs.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 3;
  // The state after IDLE already counts as the first held cycle, and the
  // cycle that sees zero is the last, hence the -2.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    ACCUM        = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic             key_m, key_s;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc_r;
  logic             ovf_r;
  logic [3:0]       count_r;
  logic             acc_valid_r;
  logic [ACC_W:0]   sum_full;

  // Two-flop synchronizer for the asynchronous load key.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_m <= 1'b0;
      key_s <= 1'b0;
    end else begin
      key_m <= bus.load_key;
      key_s <= key_m;
    end
  end

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:         if (key_s) state_nxt = DEBOUNCE;
      DEBOUNCE: begin
        if (!key_s)                 state_nxt = IDLE;
        else if (cnt == '0)         state_nxt = ACCUM;
      end
      ACCUM:        state_nxt = WAIT_RELEASE;
      WAIT_RELEASE: if (!key_s) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  // Debounce down-counter: preloaded while idle, runs while held.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= CNT_LOAD;
    end else if (state == DEBOUNCE && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign sum_full = {1'b0, acc_r} + {{(ACC_W - 4){1'b0}}, bus.sum_in};

  // Running total, sticky overflow, saturating press count; clear beats
  // an accumulation landing on the same edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      acc_r       <= '0;
      ovf_r       <= 1'b0;
      count_r     <= 4'd0;
      acc_valid_r <= 1'b0;
    end else begin
      acc_valid_r <= 1'b0;
      if (bus.clear) begin
        acc_r   <= '0;
        ovf_r   <= 1'b0;
        count_r <= 4'd0;
      end else if (state == ACCUM) begin
        acc_r       <= sum_full[ACC_W-1:0];
        ovf_r       <= ovf_r | sum_full[ACC_W];
        acc_valid_r <= 1'b1;
        if (count_r != 4'hF) count_r <= count_r + 4'd1;
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign bus.acc       = acc_r;
  assign bus.ovf       = ovf_r;
  assign bus.count     = count_r;
  assign bus.acc_valid = acc_valid_r;
  assign bus.busy      = (state != IDLE);
  assign bus.HEX0      = seg7(acc_r[3:0]);
  assign bus.HEX1      = seg7(acc_r[7:4]);

endmodule

// File: tb/tb_sum_accumulator.sv
// Randomized bench for sum_accumulator against a plain arithmetic model
// of the running total, overflow flag and press count.
module tb_sum_accumulator;

   logic CLOCK_50 = 1'b0;
   logic reset    = 1'b1;

   sum_accumulator_if #(.ACC_W(8)) bus ();

   sum_accumulator #(.DEBOUNCE_CYCLES(4), .ACC_W(8)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bus      (bus)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int errors = 0;
   int checks = 0;

   int acc_m = 0;
   bit ovf_m = 1'b0;
   int cnt_m = 0;

   logic [6:0] seg_ref [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic model_add(input int v);
      acc_m = acc_m + v;
      if (acc_m > 255) ovf_m = 1'b1;
      acc_m = acc_m % 256;
      if (cnt_m < 15) cnt_m++;
   endtask

   task automatic model_zero();
      acc_m = 0;
      ovf_m = 1'b0;
      cnt_m = 0;
   endtask

   // One full key press with the accepted value v applied only in the
   // cycle that must be sampled; random junk on sum_in at all other times.
   task automatic press(input logic [4:0] v, input int hold);
      int early;
      int late;
      logic [7:0] acc_hold;
      early = 0;
      late  = 0;
      bus.load_key = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         bus.sum_in = 5'($urandom);
         tick();
         if (bus.acc_valid !== 1'b0 || bus.acc !== 8'(acc_m)) early++;
      end
      checks++;
      if (early != 0) begin
         errors++;
         $display("FAIL press_early: %0d early changes seen, required 0", early);
      end
      bus.sum_in = v;
      tick();
      model_add(int'(v));
      checks++;
      if (bus.acc_valid !== 1'b1) begin
         errors++;
         $display("FAIL press_valid: acc_valid=%b required 1 on edge 7", bus.acc_valid);
      end
      checks++;
      if (bus.acc !== 8'(acc_m) || bus.ovf !== ovf_m || bus.count !== 4'(cnt_m)) begin
         errors++;
         $display("FAIL press_result: acc=%h ovf=%b count=%0d required acc=%h ovf=%b count=%0d",
                  bus.acc, bus.ovf, bus.count, 8'(acc_m), ovf_m, cnt_m);
      end
      checks++;
      if (bus.HEX0 !== seg_ref[acc_m % 16] || bus.HEX1 !== seg_ref[acc_m / 16]) begin
         errors++;
         $display("FAIL press_hex: HEX1=%b HEX0=%b required HEX1=%b HEX0=%b",
                  bus.HEX1, bus.HEX0, seg_ref[acc_m / 16], seg_ref[acc_m % 16]);
      end
      bus.sum_in = 5'($urandom);
      tick();
      checks++;
      if (bus.acc_valid !== 1'b0) begin
         errors++;
         $display("FAIL press_pulse_width: acc_valid=%b required 0", bus.acc_valid);
      end
      acc_hold = bus.acc;
      for (int h = 0; h < hold; h++) begin
         bus.sum_in = 5'($urandom);
         tick();
         if (bus.acc_valid !== 1'b0 || bus.acc !== acc_hold || bus.busy !== 1'b1) late++;
      end
      checks++;
      if (late != 0) begin
         errors++;
         $display("FAIL press_hold: %0d changes while held, required 0", late);
      end
      bus.load_key = 1'b0;
      repeat (4) tick();
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL press_release_busy: busy=%b required 0", bus.busy);
      end
   endtask

   task automatic test_reset();
      reset        = 1'b1;
      bus.load_key = 1'b0;
      bus.clear    = 1'b0;
      bus.sum_in   = 5'h00;
      repeat (2) tick();
      reset = 1'b0;
      model_zero();
      checks++;
      if (bus.acc !== 8'h00 || bus.ovf !== 1'b0 || bus.count !== 4'd0 ||
          bus.acc_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: acc=%h ovf=%b count=%0d valid=%b busy=%b required all 0",
                  bus.acc, bus.ovf, bus.count, bus.acc_valid, bus.busy);
      end
      checks++;
      if (bus.HEX0 !== 7'b1000000 || bus.HEX1 !== 7'b1000000) begin
         errors++;
         $display("FAIL reset_hex: HEX1=%b HEX0=%b required 1000000", bus.HEX1, bus.HEX0);
      end
   endtask

   task automatic test_basic_press();
      press(5'h13, 50);
      checks++;
      if (bus.acc !== 8'h13 || bus.count !== 4'd1 ||
          bus.HEX1 !== 7'b1111001 || bus.HEX0 !== 7'b0110000) begin
         errors++;
         $display("FAIL basic_press: acc=%h count=%0d HEX1=%b HEX0=%b required 13 1 1111001 0110000",
                  bus.acc, bus.count, bus.HEX1, bus.HEX0);
      end
   endtask

   task automatic test_glitch();
      logic [7:0] a0;
      logic [3:0] c0;
      int seen;
      for (int len = 1; len <= 3; len++) begin
         a0   = bus.acc;
         c0   = bus.count;
         seen = 0;
         bus.sum_in   = 5'h1F;
         bus.load_key = 1'b1;
         repeat (len) begin
            tick();
            if (bus.acc_valid !== 1'b0) seen++;
         end
         bus.load_key = 1'b0;
         repeat (8) begin
            tick();
            if (bus.acc_valid !== 1'b0) seen++;
         end
         checks++;
         if (seen != 0 || bus.acc !== a0 || bus.count !== c0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_len%0d: acc=%h count=%0d busy=%b pulses=%0d required acc=%h count=%0d busy=0 pulses=0",
                     len, bus.acc, bus.count, bus.busy, seen, a0, c0);
         end
      end
   endtask

   task automatic test_clear_idle();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      model_zero();
      checks++;
      if (bus.acc !== 8'h00 || bus.ovf !== 1'b0 || bus.count !== 4'd0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL clear_idle: acc=%h ovf=%b count=%0d busy=%b required 0 0 0 0",
                  bus.acc, bus.ovf, bus.count, bus.busy);
      end
   endtask

   task automatic test_overflow();
      test_clear_idle();
      repeat (7) press(5'h1F, 0);
      press(5'h17, 0);
      checks++;
      if (bus.acc !== 8'hF0 || bus.ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_setup: acc=%h ovf=%b required F0 0", bus.acc, bus.ovf);
      end
      press(5'h1F, 2);
      checks++;
      if (bus.acc !== 8'h0F || bus.ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_wrap: acc=%h ovf=%b required 0F 1", bus.acc, bus.ovf);
      end
      press(5'h01, 0);
      checks++;
      if (bus.acc !== 8'h10 || bus.ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: acc=%h ovf=%b required 10 1", bus.acc, bus.ovf);
      end
   endtask

   task automatic test_saturation();
      test_clear_idle();
      repeat (17) press(5'h01, 0);
      checks++;
      if (bus.acc !== 8'h11 || bus.count !== 4'd15) begin
         errors++;
         $display("FAIL count_saturate: acc=%h count=%0d required 11 15", bus.acc, bus.count);
      end
   endtask

   task automatic test_clear_in_accum();
      test_clear_idle();
      press(5'h11, 0);
      press(5'h11, 0);
      checks++;
      if (bus.acc !== 8'h22) begin
         errors++;
         $display("FAIL clr_accum_setup: acc=%h required 22", bus.acc);
      end
      bus.sum_in   = 5'h07;
      bus.load_key = 1'b1;
      repeat (6) tick();
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      model_zero();
      checks++;
      if (bus.acc !== 8'h00 || bus.ovf !== 1'b0 || bus.count !== 4'd0 || bus.acc_valid !== 1'b0) begin
         errors++;
         $display("FAIL clr_accum_wins: acc=%h ovf=%b count=%0d valid=%b required 0 0 0 0",
                  bus.acc, bus.ovf, bus.count, bus.acc_valid);
      end
      repeat (5) tick();
      checks++;
      if (bus.busy !== 1'b1 || bus.acc !== 8'h00 || bus.acc_valid !== 1'b0) begin
         errors++;
         $display("FAIL clr_accum_wait: busy=%b acc=%h valid=%b required 1 00 0",
                  bus.busy, bus.acc, bus.acc_valid);
      end
      bus.load_key = 1'b0;
      repeat (4) tick();
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL clr_accum_release: busy=%b required 0", bus.busy);
      end
   endtask

   task automatic test_reset_mid_debounce();
      int early;
      early = 0;
      press(5'h05, 0);
      bus.sum_in   = 5'h09;
      bus.load_key = 1'b1;
      repeat (4) tick();
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_deb_busy: busy=%b required 1 before reset", bus.busy);
      end
      reset = 1'b1;
      tick();
      model_zero();
      checks++;
      if (bus.acc !== 8'h00 || bus.ovf !== 1'b0 || bus.count !== 4'd0 ||
          bus.acc_valid !== 1'b0 || bus.busy !== 1'b0 || bus.HEX0 !== 7'b1000000) begin
         errors++;
         $display("FAIL rst_deb_values: acc=%h ovf=%b count=%0d valid=%b busy=%b HEX0=%b required reset values",
                  bus.acc, bus.ovf, bus.count, bus.acc_valid, bus.busy, bus.HEX0);
      end
      reset = 1'b0;
      for (int e = 1; e <= 6; e++) begin
         tick();
         if (bus.acc_valid !== 1'b0) early++;
      end
      checks++;
      if (early != 0) begin
         errors++;
         $display("FAIL rst_deb_early: %0d early pulses, required 0", early);
      end
      tick();
      model_add(9);
      checks++;
      if (bus.acc_valid !== 1'b1 || bus.acc !== 8'(acc_m) || bus.count !== 4'(cnt_m)) begin
         errors++;
         $display("FAIL rst_deb_accum: valid=%b acc=%h count=%0d required 1 %h %0d",
                  bus.acc_valid, bus.acc, bus.count, 8'(acc_m), cnt_m);
      end
      bus.load_key = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++) begin
         if ($urandom_range(0, 4) == 0) test_clear_idle();
         press(5'($urandom), int'($urandom_range(0, 4)));
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      bus.load_key = 1'b0;
      bus.clear    = 1'b0;
      bus.sum_in   = 5'h00;
      test_reset();
      test_basic_press();
      test_glitch();
      test_overflow();
      test_saturation();
      test_clear_in_accum();
      test_reset_mid_debounce();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
